dtmf_digit_collector: RTL and testbench

DTMF_DIGIT_COLLECTOR -- requirements
Module: dtmf_digit_collector

---
 rtl/dtmf_digit_collector.sv | 242 ++++++++++++++++++++++++
 tb/tb_dtmf_digit_collector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dtmf_digit_collector.sv
// Collects qualified DTMF digits from NUM_CH detector channels into a shared
// FIFO, adds end-of-sequence markers after idle timeouts, and exposes a small register window.
module dtmf_digit_collector #(
  parameter int          NUM_CH      = 2,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [7:0]  BASE_ADDR   = 8'h40,
  parameter logic [15:0] MIN_ON_CYC  = 16'd400,
  parameter logic [15:0] MIN_OFF_CYC = 16'd400,
  parameter logic [23:0] TIMEOUT_CYC = 24'd800000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     detect,
  input  logic [4*NUM_CH-1:0]   digit,
  input  logic                  rdena,
  input  logic                  wrena,
  input  logic [7:0]            reg_addr,
  input  logic [7:0]            wr_data,
  input  logic [7:0]            rd_data_in,
  output logic [7:0]            rd_data,
  output logic                  fifo_nonempty,
  output logic                  overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_QUALIFY, ST_PUSH, ST_RELEASE} ch_state_t;

  // ---------------- register decode ----------------
  logic [7:0] addr_off;
  logic       in_win, rd_hit, wr_hit;
  logic       pop, fifo_clr, ovf_clr;
  logic [7:0] ctrl_reg;

  assign addr_off = reg_addr - BASE_ADDR;
  assign in_win   = (addr_off[7:2] == 6'd0);
  assign rd_hit   = rdena & in_win;
  assign wr_hit   = wrena & in_win;

  // ---------------- FIFO state ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic          full, empty;
  logic [7:0]    status;

  assign full   = (count_reg == CW'(FIFO_DEPTH));
  assign empty  = (count_reg == '0);
  assign status = {overflow_reg, full, empty, 5'(count_reg)};

  assign pop      = rd_hit & (addr_off[1:0] == 2'd1) & ~empty;
  assign fifo_clr = wr_hit & (addr_off[1:0] == 2'd2) & wr_data[1];
  assign ovf_clr  = wr_hit & (addr_off[1:0] == 2'd3) & wr_data[0];

  // ---------------- channels ----------------
  logic [NUM_CH-1:0]   dig_req, eos_req, grant_dig, grant_eos;
  logic [4*NUM_CH-1:0] lat_digits;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_state_t   state_reg, state_next;
      logic [15:0] on_reg, on_next, off_reg, off_next;
      logic [23:0] to_reg, to_next;
      logic [3:0]  lat_reg, lat_next;
      logic        armed_reg, armed_next, eos_reg, eos_next;
      logic        ch_active;
      logic        det;
      logic [3:0]  dig;

      assign ch_active = ctrl_reg[0] & ctrl_reg[4+gi];
      assign det       = detect[gi];
      assign dig       = digit[4*gi +: 4];
      assign dig_req[gi] = ch_active & (state_reg == ST_PUSH);
      assign eos_req[gi] = ch_active & eos_reg;
      assign lat_digits[4*gi +: 4] = lat_reg;

      always_comb begin
        state_next = state_reg;
        on_next    = on_reg;
        off_next   = off_reg;
        to_next    = to_reg;
        lat_next   = lat_reg;
        armed_next = armed_reg;
        eos_next   = eos_reg;
        if (grant_eos[gi]) eos_next = 1'b0;
        case (state_reg)
          ST_IDLE: begin
            if (det) begin
              state_next = ST_QUALIFY;
              lat_next   = dig;
              on_next    = '0;
              armed_next = 1'b0;
              to_next    = '0;
            end else if (armed_reg) begin
              if (to_reg == TIMEOUT_CYC - 24'd1) begin
                eos_next   = 1'b1;
                armed_next = 1'b0;
                to_next    = '0;
              end else begin
                to_next = to_reg + 24'd1;
              end
            end
          end
          ST_QUALIFY: begin
            if (!det) begin
              state_next = ST_IDLE;
            end else if (dig != lat_reg) begin
              lat_next = dig;
              on_next  = '0;
            end else if (on_reg == MIN_ON_CYC - 16'd1) begin
              state_next = ST_PUSH;
            end else begin
              on_next = on_reg + 16'd1;
            end
          end
          ST_PUSH: begin
            if (grant_dig[gi]) begin
              state_next = ST_RELEASE;
              off_next   = '0;
              armed_next = 1'b1;
              to_next    = '0;
            end
          end
          ST_RELEASE: begin
            if (det) begin
              off_next = '0;
            end else if (off_reg == MIN_OFF_CYC - 16'd1) begin
              state_next = ST_IDLE;
            end else begin
              off_next = off_reg + 16'd1;
            end
          end
          default: state_next = ST_IDLE;
        endcase
        // A disabled channel is held idle with nothing armed or pending.
        if (!ch_active) begin
          state_next = ST_IDLE;
          on_next    = '0;
          off_next   = '0;
          to_next    = '0;
          armed_next = 1'b0;
          eos_next   = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_reg <= ST_IDLE;
          on_reg    <= '0;
          off_reg   <= '0;
          to_reg    <= '0;
          lat_reg   <= '0;
          armed_reg <= 1'b0;
          eos_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          on_reg    <= on_next;
          off_reg   <= off_next;
          to_reg    <= to_next;
          lat_reg   <= lat_next;
          armed_reg <= armed_next;
          eos_reg   <= eos_next;
        end
      end
    end
  endgenerate

  // ---------------- arbitration: lowest channel first, digit before EOS ----------------
  logic       push_req;
  logic [7:0] push_entry;

  always_comb begin
    grant_dig  = '0;
    grant_eos  = '0;
    push_req   = 1'b0;
    push_entry = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!push_req) begin
        if (dig_req[i]) begin
          grant_dig[i] = 1'b1;
          push_req     = 1'b1;
          push_entry   = {2'(i), 1'b0, 1'b0, lat_digits[4*i +: 4]};
        end else if (eos_req[i]) begin
          grant_eos[i] = 1'b1;
          push_req     = 1'b1;
          push_entry   = {2'(i), 1'b1, 1'b0, 4'h0};
        end
      end
    end
  end

  // A granted push is always consumed; it lands only when there is room.
  logic push_fire, push_ok, push_drop;
  assign push_fire = push_req & ~fifo_clr;
  assign push_ok   = push_fire & (~full | pop);
  assign push_drop = push_fire & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      ctrl_reg     <= 8'hF1;
      rd_data      <= '0;
    end else begin
      if (fifo_clr) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
        count_reg <= count_reg + CW'(push_ok) - CW'(pop);
      end
      if (push_drop)    overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
      if (wr_hit && addr_off[1:0] == 2'd2) ctrl_reg <= {wr_data[7:2], 1'b0, wr_data[0]};
      if (rd_hit) begin
        case (addr_off[1:0])
          2'd0:    rd_data <= status;
          2'd1:    rd_data <= empty ? 8'h00 : mem[rd_ptr_reg];
          2'd2:    rd_data <= ctrl_reg;
          default: rd_data <= 8'h00;
        endcase
      end else begin
        rd_data <= rd_data_in;
      end
    end
  end

  assign fifo_nonempty = ~empty;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_dtmf_digit_collector.sv
// Directed bench for dtmf_digit_collector with short qualify/release/timeout
// parameters; expected register values are hand-derived constants.
module tb_dtmf_digit_collector;
  localparam int          NUM_CH  = 2;
  localparam logic [7:0]  BASE    = 8'h40;
  localparam logic [7:0]  A_STAT  = BASE + 8'd0;
  localparam logic [7:0]  A_DATA  = BASE + 8'd1;
  localparam logic [7:0]  A_CTRL  = BASE + 8'd2;
  localparam logic [7:0]  A_CLR   = BASE + 8'd3;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NUM_CH-1:0]   detect = '0;
  logic [4*NUM_CH-1:0] digit = '0;
  logic                rdena = 1'b0, wrena = 1'b0;
  logic [7:0]          reg_addr = '0, wr_data = '0, rd_data_in = '0;
  logic [7:0]          rd_data;
  logic                fifo_nonempty, overflow;

  int n_vec = 0;
  int n_err = 0;

  dtmf_digit_collector #(
    .NUM_CH(NUM_CH), .FIFO_DEPTH(16), .BASE_ADDR(BASE),
    .MIN_ON_CYC(16'd8), .MIN_OFF_CYC(16'd8), .TIMEOUT_CYC(24'd200)
  ) dut (
    .clk(clk), .reset(reset), .detect(detect), .digit(digit),
    .rdena(rdena), .wrena(wrena), .reg_addr(reg_addr), .wr_data(wr_data),
    .rd_data_in(rd_data_in), .rd_data(rd_data),
    .fifo_nonempty(fifo_nonempty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_read(input logic [7:0] addr, output logic [7:0] data);
    rdena = 1'b1; reg_addr = addr;
    tick(1);
    rdena = 1'b0; reg_addr = 8'h00;
    data = rd_data;
    $display("read  %02h -> %02h", addr, data);
  endtask

  task automatic reg_write(input logic [7:0] addr, input logic [7:0] data);
    wrena = 1'b1; reg_addr = addr; wr_data = data;
    tick(1);
    wrena = 1'b0; reg_addr = 8'h00; wr_data = 8'h00;
    $display("write %02h <- %02h", addr, data);
  endtask

  task automatic tone(input logic [NUM_CH-1:0] chs, input logic [7:0] digs,
                      input int on_n, input int off_n);
    digit = digs; detect = chs;
    tick(on_n);
    detect = '0;
    tick(off_n);
  endtask

  // Drop/re-raise enable so every channel's timeout is disarmed.
  task automatic disarm();
    reg_write(A_CTRL, 8'hF0);
    reg_write(A_CTRL, 8'hF1);
  endtask

  logic [7:0] d;

  initial begin
    tick(3);
    check_val("rst_rd_data", rd_data, 8'h00);
    check_val("rst_nonempty", {7'd0, fifo_nonempty}, 8'h00);
    check_val("rst_overflow", {7'd0, overflow}, 8'h00);
    reset = 1'b1;
    tick(1);
    reg_read(A_STAT, d); check_val("rst_status", d, 8'h20);
    reg_read(A_CTRL, d); check_val("rst_ctrl", d, 8'hF1);

    // single digit on ch0
    tone(2'b01, 8'h05, 12, 10);
    check_val("d5_nonempty", {7'd0, fifo_nonempty}, 8'h01);
    reg_read(A_STAT, d); check_val("d5_status", d, 8'h01);
    reg_read(A_DATA, d); check_val("d5_data", d, 8'h05);
    check_val("d5_empty_after", {7'd0, fifo_nonempty}, 8'h00);
    reg_read(A_DATA, d); check_val("empty_data", d, 8'h00);
    disarm();

    // digit changes mid-qualify: only the final digit is pushed
    digit = 8'h05; detect = 2'b01;
    tick(4);
    digit = 8'h07;
    tick(6);
    check_val("chg_not_yet", {7'd0, fifo_nonempty}, 8'h00);
    tick(6);
    detect = '0;
    tick(10);
    reg_read(A_STAT, d); check_val("chg_status", d, 8'h01);
    reg_read(A_DATA, d); check_val("chg_data", d, 8'h07);
    disarm();

    // simultaneous qualification on both channels
    tone(2'b11, 8'h21, 12, 10);
    reg_read(A_STAT, d); check_val("dual_status", d, 8'h02);
    reg_read(A_DATA, d); check_val("dual_first", d, 8'h01);
    reg_read(A_DATA, d); check_val("dual_second", d, 8'h42);
    disarm();

    // end-of-sequence marker after idle timeout on ch1
    tone(2'b10, 8'h90, 12, 0);
    reg_read(A_DATA, d); check_val("eos_digit", d, 8'h49);
    tick(150);
    check_val("eos_not_yet", {7'd0, fifo_nonempty}, 8'h00);
    tick(100);
    reg_read(A_STAT, d); check_val("eos_status", d, 8'h01);
    reg_read(A_DATA, d); check_val("eos_entry", d, 8'h60);
    tick(300);
    reg_read(A_STAT, d); check_val("eos_once", d, 8'h20);
    disarm();

    // channel mask: only ch1 enabled
    reg_write(A_CTRL, 8'h21);
    reg_read(A_CTRL, d); check_val("mask_ctrl", d, 8'h21);
    tone(2'b11, 8'h43, 12, 10);
    reg_read(A_STAT, d); check_val("mask_status", d, 8'h01);
    reg_read(A_DATA, d); check_val("mask_data", d, 8'h44);
    reg_write(A_CTRL, 8'hF1);
    disarm();

    // overflow: 17 pushes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      tone(2'b01, {4'h0, 4'(i + 1)}, 12, 12);
    end
    disarm();
    reg_read(A_STAT, d); check_val("ovf_status", d, 8'hD0);
    check_val("ovf_flag", {7'd0, overflow}, 8'h01);
    reg_write(A_CLR, 8'h01);
    reg_read(A_STAT, d); check_val("ovf_cleared", d, 8'h50);
    reg_read(A_CLR, d); check_val("clr_reads0", d, 8'h00);
    reg_read(A_DATA, d); check_val("ovf_head", d, 8'h01);
    reg_read(A_STAT, d); check_val("ovf_after_pop", d, 8'h0F);

    // daisy-chained read outside the window: no pop
    rd_data_in = 8'hA5;
    reg_read(BASE + 8'd8, d); check_val("chain_read", d, 8'hA5);
    rd_data_in = 8'h3C;
    tick(1);
    check_val("chain_idle", rd_data, 8'h3C);
    rd_data_in = 8'h00;
    reg_read(A_STAT, d); check_val("chain_nopop", d, 8'h0F);
    reg_read(A_DATA, d); check_val("chain_next", d, 8'h02);

    // FIFO clear via CTRL
    reg_write(A_CTRL, 8'hF3);
    reg_read(A_STAT, d); check_val("fclr_status", d, 8'h20);
    reg_read(A_CTRL, d); check_val("fclr_ctrl", d, 8'hF1);

    // reset in the middle of qualification abandons the digit
    reg_write(A_CTRL, 8'h31);
    digit = 8'h08; detect = 2'b01;
    tick(5);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    detect = '0;
    tick(20);
    reg_read(A_STAT, d); check_val("midrst_status", d, 8'h20);
    reg_read(A_CTRL, d); check_val("midrst_ctrl", d, 8'hF1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
